// File: rtl/multi_tick_timer.sv
// Multi-channel game timer: a shared prescaler produces a base tick, and each channel
// counts base ticks down from its period, emitting one-cycle expiry pulses.
module multi_tick_timer #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int BASE_HZ         = 1000,
    parameter int SIMULATION_MODE = 0,
    parameter int SIM_DIV         = 10,
    parameter int NUM_CH          = 4,
    parameter int CNT_W           = 16
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    enable,
    input  logic [1:0]              speed,
    input  logic [NUM_CH-1:0]       ch_start,
    input  logic [NUM_CH-1:0]       ch_stop,
    input  logic [NUM_CH-1:0]       ch_oneshot,
    input  logic [NUM_CH*CNT_W-1:0] ch_period,
    output logic                    base_tick,
    output logic [NUM_CH-1:0]       ch_tick,
    output logic [NUM_CH-1:0]       ch_busy
);

    localparam int BASE_DIV = (SIMULATION_MODE != 0) ? SIM_DIV : CLK_HZ / BASE_HZ;

    function automatic int div_for(input int f);
        return (BASE_DIV / f < 1) ? 1 : BASE_DIV / f;
    endfunction

    localparam int PRE_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
    localparam logic [PRE_W-1:0] LIM_X1  = PRE_W'(div_for(1) - 1);
    localparam logic [PRE_W-1:0] LIM_X2  = PRE_W'(div_for(2) - 1);
    localparam logic [PRE_W-1:0] LIM_X4  = PRE_W'(div_for(4) - 1);
    localparam logic [PRE_W-1:0] LIM_X10 = PRE_W'(div_for(10) - 1);

    logic [PRE_W-1:0] lim;
    logic [PRE_W-1:0] pre_q;
    logic             tick_q;

    always_comb begin
        case (speed)
            2'b00:   lim = LIM_X1;
            2'b01:   lim = LIM_X2;
            2'b10:   lim = LIM_X4;
            default: lim = LIM_X10;
        endcase
    end

    // A pending tick stays held while disabled, so a freeze delays expiry by exactly
    // the number of disabled cycles instead of losing a tick.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else if (enable) begin
            if (pre_q >= lim) begin
                pre_q  <= '0;
                tick_q <= 1'b1;
            end else begin
                pre_q  <= pre_q + 1'b1;
                tick_q <= 1'b0;
            end
        end
    end

    assign base_tick = tick_q & enable;

    typedef enum logic {IDLE, RUN} ch_state_t;

    ch_state_t        state_q [NUM_CH];
    ch_state_t        state_d [NUM_CH];
    logic [CNT_W-1:0] cnt_q   [NUM_CH];
    logic [CNT_W-1:0] cnt_d   [NUM_CH];
    logic [CNT_W-1:0] period  [NUM_CH];
    logic [NUM_CH-1:0] os_q, os_d, tick_d;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            period[i] = ch_period[i*CNT_W +: CNT_W];
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            os_q    <= '0;
            ch_tick <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            os_q    <= os_d;
            ch_tick <= tick_d;
        end
    end

    // Priority: stop, then start/restart, then base-tick countdown.
    always_comb begin
        os_d   = os_q;
        tick_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (ch_stop[i]) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end else if (ch_start[i]) begin
                if (period[i] != '0) begin
                    state_d[i] = RUN;
                    cnt_d[i]   = period[i];
                    os_d[i]    = ch_oneshot[i];
                end else begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            end else if (state_q[i] == RUN && base_tick) begin
                if (cnt_q[i] > CNT_W'(1)) begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end else begin
                    tick_d[i] = 1'b1;
                    if (os_q[i] || period[i] == '0) begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = period[i];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_busy[i] = (state_q[i] == RUN);
        end
    end

endmodule

// File: tb/tb_multi_tick_timer.sv
// Bench for multi_tick_timer: directed timing scenarios plus random traffic, all
// compared every cycle against a tick-counting reference model.
module tb_multi_tick_timer;

    localparam int NCH = 4;
    localparam int CW  = 16;

    logic            clk, resetN, enable;
    logic [1:0]      speed;
    logic [NCH-1:0]  ch_start, ch_stop, ch_oneshot;
    logic [NCH*CW-1:0] ch_period;
    logic            base_tick;
    logic [NCH-1:0]  ch_tick, ch_busy;

    multi_tick_timer #(
        .CLK_HZ(50_000_000), .BASE_HZ(1000), .SIMULATION_MODE(1), .SIM_DIV(10),
        .NUM_CH(NCH), .CNT_W(CW)
    ) dut (
        .clk(clk), .resetN(resetN), .enable(enable), .speed(speed),
        .ch_start(ch_start), .ch_stop(ch_stop), .ch_oneshot(ch_oneshot),
        .ch_period(ch_period), .base_tick(base_tick), .ch_tick(ch_tick), .ch_busy(ch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // reference model: enabled-cycle phase, pending base tick, base ticks left per channel
    int             m_pre;
    bit             m_pend;
    bit             m_run  [NCH];
    int             m_left [NCH];
    bit             m_os   [NCH];
    logic [NCH-1:0] m_tick;

    int bt_count, last_bt;
    int tick_cnt [NCH];
    int last_tick[NCH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int div_of(input logic [1:0] s);
        int f;
        f = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : (s == 2'd2) ? 4 : 10;
        return (10 / f < 1) ? 1 : 10 / f;
    endfunction

    function automatic logic [NCH-1:0] m_busy();
        logic [NCH-1:0] b;
        for (int i = 0; i < NCH; i++) b[i] = m_run[i];
        return b;
    endfunction

    task automatic model_reset();
        m_pre = 0; m_pend = 0; m_tick = '0;
        for (int i = 0; i < NCH; i++) begin
            m_run[i] = 0; m_left[i] = 0; m_os[i] = 0;
        end
    endtask

    task automatic model_step();
        bit bt;
        int per;
        bt = m_pend && enable;
        for (int i = 0; i < NCH; i++) begin
            per = int'(ch_period[i*CW +: CW]);
            m_tick[i] = 1'b0;
            if (ch_stop[i]) begin
                m_run[i] = 0; m_left[i] = 0;
            end else if (ch_start[i]) begin
                m_run[i] = (per != 0); m_left[i] = per; m_os[i] = ch_oneshot[i];
            end else if (m_run[i] && bt) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    m_tick[i] = 1'b1;
                    if (m_os[i] || per == 0) m_run[i] = 0;
                    else m_left[i] = per;
                end
            end
        end
        if (enable) begin
            if (m_pre >= div_of(speed) - 1) begin
                m_pre = 0; m_pend = 1;
            end else begin
                m_pre++; m_pend = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        check("base_tick", base_tick, m_pend && enable);
        check("ch_tick", ch_tick, m_tick);
        check("ch_busy", ch_busy, m_busy());
        if (base_tick) begin bt_count++; last_bt = cyc; end
        for (int i = 0; i < NCH; i++)
            if (ch_tick[i]) begin tick_cnt[i]++; last_tick[i] = cyc; end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_bt(input int bound);
        int b0, n;
        b0 = bt_count; n = 0;
        while (bt_count == b0 && n < bound) begin cycle(); n++; end
        if (bt_count == b0) check("bt_timeout", 0, 1);
    endtask

    task automatic wait_tick(input int ch, input int bound);
        int t0, n;
        t0 = tick_cnt[ch]; n = 0;
        while (tick_cnt[ch] == t0 && n < bound) begin cycle(); n++; end
        if (tick_cnt[ch] == t0) check("tick_timeout", ch, 99);
    endtask

    task automatic set_period(input int ch, input int per);
        ch_period[ch*CW +: CW] = CW'(per);
    endtask

    task automatic pulse_start(input int ch, input bit os, input int per);
        set_period(ch, per);
        ch_oneshot[ch] = os;
        ch_start[ch] = 1'b1;
        cycle();
        ch_start[ch] = 1'b0;
    endtask

    task automatic pulse_stop(input int ch);
        ch_stop[ch] = 1'b1;
        cycle();
        ch_stop[ch] = 1'b0;
    endtask

    task automatic apply_reset();
        #3 resetN = 1'b0;
        #1;
        check("rst_base_tick", base_tick, 0);
        check("rst_ch_tick", ch_tick, 0);
        check("rst_ch_busy", ch_busy, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        int s, d, b0, t0;
        int exp_rate[4] = '{10, 5, 2, 1};
        resetN = 1'b0; enable = 1'b0; speed = 2'd0;
        ch_start = '0; ch_stop = '0; ch_oneshot = '0; ch_period = '0;
        bt_count = 0; last_bt = 0;
        for (int i = 0; i < NCH; i++) begin tick_cnt[i] = 0; last_tick[i] = 0; end
        model_reset();
        #12;
        check("reset_base_tick", base_tick, 0);
        check("reset_ch_tick", ch_tick, 0);
        check("reset_ch_busy", ch_busy, 0);
        @(negedge clk);
        resetN = 1'b1;
        enable = 1'b1;
        run(3);

        // prescaler rate at each speed
        for (int sp = 0; sp < 4; sp++) begin
            speed = 2'(sp);
            wait_bt(30);
            t0 = last_bt;
            wait_bt(30);
            check($sformatf("rate_speed%0d", sp), last_bt - t0, exp_rate[sp]);
        end

        // periodic channel 0, period 3
        speed = 2'd0;
        run($urandom_range(0, 9));
        pulse_start(0, 1'b0, 3);
        s = cyc;
        wait_tick(0, 40);
        d = last_tick[0] - s;
        check("periodic_first_window", (d >= 21 && d <= 30), 1);
        for (int k = 0; k < 3; k++) begin
            t0 = last_tick[0];
            wait_tick(0, 40);
            check("periodic_interval", last_tick[0] - t0, 30);
            check("periodic_busy", ch_busy[0], 1);
        end
        pulse_stop(0);

        // one-shot channel 1, period 2
        run($urandom_range(0, 9));
        pulse_start(1, 1'b1, 2);
        s = cyc;
        wait_tick(1, 30);
        d = last_tick[1] - s;
        check("oneshot_window", (d >= 11 && d <= 20), 1);
        check("oneshot_busy_drop", ch_busy[1], 0);
        t0 = tick_cnt[1];
        run(200);
        check("oneshot_no_more", tick_cnt[1] - t0, 0);

        // stop beats expiry on channel 2, then a zero-period start is ignored
        pulse_start(2, 1'b0, 1);
        d = 0;
        while (!(m_pend && enable) && d < 20) begin cycle(); d++; end
        t0 = tick_cnt[2];
        pulse_stop(2);
        check("stop_expiry_tick", ch_tick[2], 0);
        check("stop_expiry_busy", ch_busy[2], 0);
        run(25);
        check("stop_no_late_tick", tick_cnt[2] - t0, 0);
        pulse_start(2, 1'b0, 0);
        check("zero_period_busy", ch_busy[2], 0);
        run(25);
        check("zero_period_idle", ch_busy[2], 0);

        // restart channel 3 after two base ticks
        pulse_start(3, 1'b0, 4);
        t0 = tick_cnt[3];
        wait_bt(20);
        wait_bt(20);
        b0 = bt_count;
        pulse_start(3, 1'b0, 4);
        check("restart_no_tick", tick_cnt[3] - t0, 0);
        wait_tick(3, 60);
        check("restart_full_count", bt_count - b0, 4);

        // freeze mid-count: next periodic tick slips by exactly 50 cycles
        t0 = last_tick[3];
        run(15);
        enable = 1'b0;
        b0 = bt_count;
        d = tick_cnt[3];
        run(50);
        check("freeze_no_base_tick", bt_count - b0, 0);
        check("freeze_no_ch_tick", tick_cnt[3] - d, 0);
        enable = 1'b1;
        wait_tick(3, 100);
        check("freeze_interval", last_tick[3] - t0, 90);
        pulse_stop(3);

        // asynchronous reset mid-count
        pulse_start(0, 1'b0, 3);
        pulse_start(1, 1'b1, 5);
        run(17);
        apply_reset();
        run(40);
        check("post_reset_idle", ch_busy, 0);

        // speed change with the prescaler at 7
        speed = 2'd0;
        wait_bt(20);
        run(7);
        speed = 2'd3;
        cycle();
        check("speed_change_wrap", base_tick, 1);
        speed = 2'd0;
        run(12);

        // random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            enable = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 99) == 0) speed = 2'($urandom_range(0, 3));
            for (int i = 0; i < NCH; i++) begin
                ch_start[i] = ($urandom_range(0, 29) == 0);
                ch_stop[i] = ($urandom_range(0, 59) == 0);
                ch_oneshot[i] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 9) == 0) set_period(i, $urandom_range(0, 6));
            end
            cycle();
        end
        ch_start = '0; ch_stop = '0;
        run(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
